// File: rtl/midi_voice_alloc.sv
// MIDI note-on/note-off parser with running status feeding a 4-voice allocator.
// Voices are stolen oldest-first using a 2-bit age rank per voice.
module midi_voice_alloc #(
    parameter bit         OMNI    = 1'b1,
    parameter logic [3:0] CHANNEL = 4'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic [3:0]  voice_active,
    output logic [27:0] voice_note,
    output logic [27:0] voice_vel,
    output logic        steal,
    output logic [7:0]  led_out
);
    typedef enum logic [1:0] {NOSTAT, WAIT_D1, WAIT_D2} state_t;

    state_t          state_q, state_d;
    logic            rs_on_q, rs_on_d;
    logic [6:0]      note_lat_q, note_lat_d;
    logic            ev_vld_q, ev_vld_d;
    logic            ev_on_q, ev_on_d;
    logic [6:0]      ev_note_q, ev_note_d;
    logic [6:0]      ev_vel_q, ev_vel_d;

    logic [3:0]      active_q, active_d;
    logic [3:0][6:0] note_q, note_d;
    logic [3:0][6:0] vel_q, vel_d;
    logic [3:0][1:0] rank_q, rank_d;
    logic            steal_q, steal_d;
    logic [6:0]      led_q, led_d;

    always_comb begin
        state_d    = state_q;
        rs_on_d    = rs_on_q;
        note_lat_d = note_lat_q;
        ev_vld_d   = 1'b0;
        ev_on_d    = ev_on_q;
        ev_note_d  = ev_note_q;
        ev_vel_d   = ev_vel_q;
        if (byte_valid) begin
            if (byte_in[7]) begin
                // 0xF8-0xFF realtime bytes fall through untouched
                if (byte_in[7:3] != 5'b11111) begin
                    if ((byte_in[7:4] == 4'h8 || byte_in[7:4] == 4'h9) &&
                        (OMNI || byte_in[3:0] == CHANNEL)) begin
                        state_d = WAIT_D1;
                        rs_on_d = byte_in[4];
                    end else begin
                        state_d = NOSTAT;
                    end
                end
            end else begin
                case (state_q)
                    WAIT_D1: begin
                        note_lat_d = byte_in[6:0];
                        state_d    = WAIT_D2;
                    end
                    WAIT_D2: begin
                        ev_vld_d  = 1'b1;
                        ev_on_d   = rs_on_q && (byte_in[6:0] != 7'd0);
                        ev_note_d = note_lat_q;
                        ev_vel_d  = byte_in[6:0];
                        state_d   = WAIT_D1;
                    end
                    default: ;
                endcase
            end
        end
    end

    logic       m_hit, f_hit;
    logic [1:0] m_sel, f_sel, o_sel, sel, old_rank;
    logic [1:0] o_rank;

    always_comb begin
        m_hit = 1'b0;
        m_sel = 2'd0;
        f_hit = 1'b0;
        f_sel = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (active_q[i] && note_q[i] == ev_note_q) begin
                m_hit = 1'b1;
                m_sel = 2'(i);
            end
            if (!active_q[i]) begin
                f_hit = 1'b1;
                f_sel = 2'(i);
            end
        end
        // Oldest = highest rank, lowest index on a tie
        o_sel  = 2'd0;
        o_rank = rank_q[0];
        for (int i = 1; i < 4; i++) begin
            if (rank_q[i] > o_rank) begin
                o_rank = rank_q[i];
                o_sel  = 2'(i);
            end
        end
    end

    always_comb begin
        active_d = active_q;
        note_d   = note_q;
        vel_d    = vel_q;
        rank_d   = rank_q;
        steal_d  = 1'b0;
        led_d    = led_q;
        sel      = o_sel;
        old_rank = 2'd3;
        if (ev_vld_q) begin
            if (ev_on_q) begin
                if (m_hit) begin
                    sel      = m_sel;
                    old_rank = rank_q[m_sel];
                end else if (f_hit) begin
                    sel = f_sel;
                end else begin
                    steal_d = 1'b1;
                end
                for (int i = 0; i < 4; i++) begin
                    if (2'(i) == sel)
                        rank_d[i] = 2'd0;
                    else if (rank_q[i] < old_rank)
                        rank_d[i] = rank_q[i] + 2'd1;
                end
                active_d[sel] = 1'b1;
                note_d[sel]   = ev_note_q;
                vel_d[sel]    = ev_vel_q;
                led_d         = ev_note_q;
            end else if (m_hit) begin
                active_d[m_sel] = 1'b0;
            end
        end
        if (active_d == 4'b0000)
            led_d = 7'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= NOSTAT;
            rs_on_q    <= 1'b0;
            note_lat_q <= 7'd0;
            ev_vld_q   <= 1'b0;
            ev_on_q    <= 1'b0;
            ev_note_q  <= 7'd0;
            ev_vel_q   <= 7'd0;
            active_q   <= 4'b0000;
            note_q     <= '0;
            vel_q      <= '0;
            rank_q     <= {2'd0, 2'd1, 2'd2, 2'd3};
            steal_q    <= 1'b0;
            led_q      <= 7'd0;
        end else begin
            state_q    <= state_d;
            rs_on_q    <= rs_on_d;
            note_lat_q <= note_lat_d;
            ev_vld_q   <= ev_vld_d;
            ev_on_q    <= ev_on_d;
            ev_note_q  <= ev_note_d;
            ev_vel_q   <= ev_vel_d;
            active_q   <= active_d;
            note_q     <= note_d;
            vel_q      <= vel_d;
            rank_q     <= rank_d;
            steal_q    <= steal_d;
            led_q      <= led_d;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_out
        assign voice_note[7*g +: 7] = note_q[g];
        assign voice_vel[7*g +: 7]  = vel_q[g];
    end
    assign voice_active = active_q;
    assign steal        = steal_q;
    assign led_out      = {1'b0, led_q};
endmodule

// File: doc/midi_voice_alloc.md
MIDI_VOICE_ALLOC -- requirements
Module: midi_voice_alloc

Interface
REQ-001 Parameter OMNI, default 1: 1 = accept all 16 channels; 0 = accept only CHANNEL.
REQ-002 Parameter CHANNEL, default 4'h0: accepted MIDI channel when OMNI=0.
REQ-003 Port clk  in  1: single clock; all state on posedge clk.
REQ-004 Port rst_n  in  1: reset, asynchronous and active-low.
REQ-005 Port byte_in  in  8: received MIDI byte from the serial receiver.
REQ-006 Port byte_valid  in  1: byte_in valid this cycle; 1-cycle pulse per byte; back-to-back pulses allowed.
REQ-007 Port voice_active  out  4: bit i = voice i sounding.
REQ-008 Port voice_note  out  28: voice i note number in bits [7i+6:7i].
REQ-009 Port voice_vel  out  28: voice i velocity in bits [7i+6:7i].
REQ-010 Port steal  out  1: 1-cycle pulse when an active voice is reassigned.
REQ-011 Port led_out  out  8: {1'b0, most recent accepted note-on note}, for LED display.

Function
REQ-012 Parser states: NOSTAT (no running status), WAIT_D1, WAIT_D2; parser advances only on byte_valid.
REQ-013 Status 0x8n/0x9n with accepted channel: store running status (kind, channel), go to WAIT_D1 from any state, discarding any partial message.
REQ-014 Status 0x80-0xEF with any other kind or rejected channel, or 0xF0-0xF7: clear running status, go to NOSTAT.
REQ-015 Realtime bytes 0xF8-0xFF: ignored; parser state and running status unchanged.
REQ-016 Data byte (bit7=0) in WAIT_D1: latch note, go to WAIT_D2.
REQ-017 Data byte in WAIT_D2: latch velocity, raise event, return to WAIT_D1 (running status kept).
REQ-018 Data byte in NOSTAT: ignored.
REQ-019 Event classification: 0x9n with vel>0 = NOTE_ON; 0x8n any vel, or 0x9n with vel=0 = NOTE_OFF.
REQ-020 Event commits to voice outputs on the posedge after the cycle in which the velocity byte is accepted (1-cycle latency).
REQ-021 NOTE_ON, note matches an active voice: update that voice's velocity, make it youngest, no steal.
REQ-022 NOTE_ON, no match, a free voice exists: assign lowest-index free voice, set active, make it youngest.
REQ-023 NOTE_ON, no match, all 4 active: reassign the oldest voice (age rank 3), make it youngest, pulse steal for 1 cycle.
REQ-024 Age: each voice holds a 2-bit rank; on assign/retrigger the chosen voice gets rank 0 and every voice whose rank was lower than its old rank increments; free-voice assignment treats the old rank as 3.
REQ-025 NOTE_OFF: clear voice_active of the matching active voice; note/vel fields retained; no match -> no change; ranks unchanged.
REQ-026 At most one voice may hold a given note among active voices.
REQ-027 led_out updates on every committed NOTE_ON; cleared to 8'h00 in the cycle voice_active becomes 4'b0000.
REQ-028 A new byte arriving in the commit cycle is parsed normally; commit and parse never conflict since an event needs at least two bytes.

Reset
REQ-029 rst_n low: parser to NOSTAT, running status cleared, voice_active=0, voice_note=0, voice_vel=0, ranks={3,2,1,0} for voices 0..3, steal=0, led_out=0, pending event dropped.
REQ-030 Reset mid-message: partial message discarded; first data byte after release is ignored until a new status byte arrives.

Verification
REQ-031 Bytes 90 3C 40 -> 1 cycle after last byte: voice_active=0001, voice 0 note 3C vel 40, led_out=3C.
REQ-032 90 3C 40, 3E 50 (running status), 80 3C 00 -> voice_active=0010, voice 1 note 3E; led_out=3E.
REQ-033 90 40 10, 41 10, 42 10, 43 10, 44 10 -> fifth note replaces voice 0 (note 44), steal pulses once, voice_active=1111.
REQ-034 90 3C 40, FE inserted between 3C and 40, then 3C 00 -> note on committed despite FE; then voice 0 released by vel 0; led_out=00.
REQ-035 OMNI=0, CHANNEL=1: 90 3C 40 -> no change; 91 3C 40 -> voice 0 active; B1 07 7F then 3C 00 -> data ignored, voice 0 still active.
REQ-036 rst_n pulsed low after 90 3C -> all outputs 0; subsequent 40 ignored; voice_active stays 0000.
